// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one req/ack transaction per load/store,
// with store lane steering, load extension, misalign detection and bus timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] load_data,
  output logic        stall_mem,
  output logic        acc_fault,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        acc, legal, aligned, go, tmo;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] lane_w;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;

  assign acc = mem_re | mem_we;
  assign go  = (state == IDLE) && acc && legal && aligned;
  assign tmo = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    legal = 1'b0;
    if (mem_we)
      legal = !funct3[2] && (funct3[1:0] != 2'b11);
    else
      legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
  end

  always_comb begin
    aligned = 1'b0;
    unique case (1'b1)
      funct3[1:0] == 2'b00: aligned = 1'b1;
      funct3[1:0] == 2'b01: aligned = !addr[0];
      funct3[1:0] == 2'b10: aligned = (addr[1:0] == 2'b00);
      default:              aligned = 1'b0;
    endcase
  end

  always_comb begin
    wstrb_n = 4'h0;
    wdata_n = wdata;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        wstrb_n = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      funct3[1:0] == 2'b01: begin
        wstrb_n = 4'b0011 << {addr[1], 1'b0};
        wdata_n = {2{wdata[15:0]}};
      end
      default: wstrb_n = 4'hF;
    endcase
    if (!mem_we)
      wstrb_n = 4'h0;
  end

  // Offset and size were latched at issue; upstream inputs are frozen anyway.
  always_comb begin
    lane_w = dm_rdata >> {off_q, 3'b000};
    lane_b = lane_w[7:0];
    lane_h = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ext    = dm_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ext = {{24{lane_b[7]}}, lane_b};
      f3_q == 3'b100: ext = {24'h0, lane_b};
      f3_q == 3'b001: ext = {{16{lane_h[15]}}, lane_h};
      f3_q == 3'b101: ext = {16'h0, lane_h};
      default:        ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (go) state_n = REQ;
      REQ: begin
        if (dm_ack)   state_n = DONE;
        else if (tmo) state_n = ERR;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      dm_wstrb  <= '0;
      load_data <= '0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (go) begin
          dm_req   <= 1'b1;
          dm_we    <= mem_we;
          dm_addr  <= {addr[31:2], 2'b00};
          dm_wdata <= wdata_n;
          dm_wstrb <= wstrb_n;
          f3_q     <= funct3;
          off_q    <= addr[1:0];
        end else if (acc) begin
          load_data <= '0;
        end
      end else if (state == REQ) begin
        if (dm_ack) begin
          load_data <= ext;
          dm_req    <= 1'b0;
          cnt       <= '0;
        end else if (tmo) begin
          load_data <= '0;
          dm_req    <= 1'b0;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign stall_mem = go || (state == REQ);
  assign acc_fault = !rst && (state == IDLE) && acc && !(legal && aligned);
  assign bus_err   = (state == ERR);

endmodule
